// File: rtl/obi_mux_2_to_1.sv
// obi_mux_2_to_1: merges two OBI controllers onto one slave port.
// The address phase is arbitrated round-robin, and a stalled request stays locked
// to its controller until it is granted. Responses are routed back through a small
// in-order FIFO of controller ids.
module obi_mux_2_to_1 #(
    parameter int unsigned MAX_OUTSTANDING = 2,     // response-routing FIFO depth, 1..8
    parameter bit          WRITE_RESP      = 1'b0   // 1: accepted writes also return an rvalid
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        ctrl1_req_i,
    output logic        ctrl1_gnt_o,
    input  logic [31:0] ctrl1_addr_i,
    input  logic        ctrl1_we_i,
    input  logic [3:0]  ctrl1_be_i,
    input  logic [31:0] ctrl1_wdata_i,
    output logic        ctrl1_rvalid_o,
    output logic [31:0] ctrl1_rdata_o,

    input  logic        ctrl2_req_i,
    output logic        ctrl2_gnt_o,
    input  logic [31:0] ctrl2_addr_i,
    input  logic        ctrl2_we_i,
    input  logic [3:0]  ctrl2_be_i,
    input  logic [31:0] ctrl2_wdata_i,
    output logic        ctrl2_rvalid_o,
    output logic [31:0] ctrl2_rdata_o,

    output logic        port_req_o,
    input  logic        port_gnt_i,
    output logic [31:0] port_addr_o,
    output logic        port_we_o,
    output logic [3:0]  port_be_o,
    output logic [31:0] port_wdata_o,
    input  logic        port_rvalid_i,
    input  logic [31:0] port_rdata_i,

    output logic        bad_state_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {CTRL1 = 1'b0, CTRL2 = 1'b1} ctrl_e;
    typedef enum logic {S_OPEN = 1'b0, S_LOCKED = 1'b1} lock_e;

    // Arbitration and lock state
    lock_e            r_lock_state;
    lock_e            w_lock_next;
    ctrl_e            r_locked_sel;
    ctrl_e            w_locked_sel_next;
    ctrl_e            r_prio;
    ctrl_e            w_sel;
    logic             w_req_sel;
    logic             w_handshake;
    logic             w_lock_drop;

    // Response-routing FIFO
    ctrl_e            r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_fifo_full;
    logic             w_fifo_nonempty;
    ctrl_e            w_head;
    logic             w_push;
    logic             w_pop;

    logic             r_bad_state;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign w_fifo_full     = (r_count == MAX_CNT);
    assign w_fifo_nonempty = (r_count != '0);
    assign w_head          = r_fifo[r_rd_ptr];

    // Select a controller: a held lock wins, then the single requester, then prio on contention.
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        w_sel = CTRL1;
        if (r_lock_state == S_LOCKED) begin
            w_sel = r_locked_sel;
        end else if (ctrl1_req_i && ctrl2_req_i) begin
            w_sel = r_prio;
        end else if (ctrl2_req_i) begin
            w_sel = CTRL2;
        end
    end

    // Drive the address phase of the selected controller onto the slave port.
    always_comb begin
        w_req_sel    = ctrl1_req_i;
        port_addr_o  = ctrl1_addr_i;
        port_we_o    = ctrl1_we_i;
        port_be_o    = ctrl1_be_i;
        port_wdata_o = ctrl1_wdata_i;
        if (w_sel == CTRL2) begin
            w_req_sel    = ctrl2_req_i;
            port_addr_o  = ctrl2_addr_i;
            port_we_o    = ctrl2_we_i;
            port_be_o    = ctrl2_be_i;
            port_wdata_o = ctrl2_wdata_i;
        end
    end

    assign port_req_o  = w_req_sel && !w_fifo_full;
    assign w_handshake = port_req_o && port_gnt_i;
    assign ctrl1_gnt_o = w_handshake && (w_sel == CTRL1);
    assign ctrl2_gnt_o = w_handshake && (w_sel == CTRL2);

    assign w_push = w_handshake && (!port_we_o || WRITE_RESP);
    assign w_pop  = port_rvalid_i && w_fifo_nonempty;

    // Lock next state: a stalled request pins the selection until its handshake or until its req drops.
    always_comb begin
        w_lock_next       = r_lock_state;
        w_locked_sel_next = r_locked_sel;
        w_lock_drop       = 1'b0;
        case (r_lock_state)
            S_OPEN: begin
                if (port_req_o && !port_gnt_i) begin
                    w_lock_next       = S_LOCKED;
                    w_locked_sel_next = w_sel;
                end
            end
            S_LOCKED: begin
                if (!w_req_sel) begin
                    w_lock_drop = 1'b1;
                    w_lock_next = S_OPEN;
                end else if (w_handshake) begin
                    w_lock_next = S_OPEN;
                end
            end
            default: w_lock_next = S_OPEN;
        endcase
    end

    // Arbitration state registers: lock, locked selection and round-robin priority.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            r_lock_state <= S_OPEN;
            r_locked_sel <= CTRL1;
            r_prio       <= CTRL1;
        end else begin
            r_lock_state <= w_lock_next;
            r_locked_sel <= w_locked_sel_next;
            if (w_handshake) begin
                r_prio <= (w_sel == CTRL1) ? CTRL2 : CTRL1;
            end
        end
    end

    // FIFO storage: remember which controller owns each outstanding response.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_sel;
        end
    end

    // FIFO pointers and occupancy count; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle flag for an orphan response or a locked requester that gave up.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bad_state <= 1'b0;
        end else begin
            r_bad_state <= (port_rvalid_i && !w_fifo_nonempty) || w_lock_drop;
        end
    end

    assign bad_state_o = r_bad_state;

    assign ctrl1_rvalid_o = port_rvalid_i && w_fifo_nonempty && (w_head == CTRL1);
    assign ctrl2_rvalid_o = port_rvalid_i && w_fifo_nonempty && (w_head == CTRL2);
    assign ctrl1_rdata_o  = (w_fifo_nonempty && (w_head == CTRL1)) ? port_rdata_i : '0;
    assign ctrl2_rdata_o  = (w_fifo_nonempty && (w_head == CTRL2)) ? port_rdata_i : '0;

endmodule

// File: tb/tb_obi_mux_2_to_1.sv
// Testbench for obi_mux_2_to_1: directed scenarios plus randomized traffic.
// Each cycle is checked against a transaction-level model that keeps a queue of outstanding owners.
module tb_obi_mux_2_to_1;

    localparam int unsigned MAX_OUT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ctrl1_req_i, ctrl2_req_i;
    logic        ctrl1_gnt_o, ctrl2_gnt_o;
    logic [31:0] ctrl1_addr_i, ctrl2_addr_i;
    logic        ctrl1_we_i, ctrl2_we_i;
    logic [3:0]  ctrl1_be_i, ctrl2_be_i;
    logic [31:0] ctrl1_wdata_i, ctrl2_wdata_i;
    logic        ctrl1_rvalid_o, ctrl2_rvalid_o;
    logic [31:0] ctrl1_rdata_o, ctrl2_rdata_o;
    logic        port_req_o, port_gnt_i;
    logic [31:0] port_addr_o;
    logic        port_we_o;
    logic [3:0]  port_be_o;
    logic [31:0] port_wdata_o;
    logic        port_rvalid_i;
    logic [31:0] port_rdata_i;
    logic        bad_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: owners of outstanding responses in issue order (0=ctrl1, 1=ctrl2).
    bit m_q[$];
    bit m_prio;
    bit m_lock;
    bit m_lsel;
    bit m_bad;

    obi_mux_2_to_1 #(.MAX_OUTSTANDING(MAX_OUT), .WRITE_RESP(1'b0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ctrl1_req_i(ctrl1_req_i), .ctrl1_gnt_o(ctrl1_gnt_o), .ctrl1_addr_i(ctrl1_addr_i),
        .ctrl1_we_i(ctrl1_we_i), .ctrl1_be_i(ctrl1_be_i), .ctrl1_wdata_i(ctrl1_wdata_i),
        .ctrl1_rvalid_o(ctrl1_rvalid_o), .ctrl1_rdata_o(ctrl1_rdata_o),
        .ctrl2_req_i(ctrl2_req_i), .ctrl2_gnt_o(ctrl2_gnt_o), .ctrl2_addr_i(ctrl2_addr_i),
        .ctrl2_we_i(ctrl2_we_i), .ctrl2_be_i(ctrl2_be_i), .ctrl2_wdata_i(ctrl2_wdata_i),
        .ctrl2_rvalid_o(ctrl2_rvalid_o), .ctrl2_rdata_o(ctrl2_rdata_o),
        .port_req_o(port_req_o), .port_gnt_i(port_gnt_i), .port_addr_o(port_addr_o),
        .port_we_o(port_we_o), .port_be_o(port_be_o), .port_wdata_o(port_wdata_o),
        .port_rvalid_i(port_rvalid_i), .port_rdata_i(port_rdata_i),
        .bad_state_o(bad_state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        ctrl1_req_i = 0; ctrl1_addr_i = '0; ctrl1_we_i = 0; ctrl1_be_i = '0; ctrl1_wdata_i = '0;
        ctrl2_req_i = 0; ctrl2_addr_i = '0; ctrl2_we_i = 0; ctrl2_be_i = '0; ctrl2_wdata_i = '0;
        port_gnt_i = 0; port_rvalid_i = 0; port_rdata_i = '0;
    endtask

    // Compare every output against the model, then advance the model to the next edge.
    task automatic model_step();
        bit full, sel, rs, preq, ne, head, hs, drop, we_sel;
        full = (m_q.size() == MAX_OUT);
        if (m_lock)                          sel = m_lsel;
        else if (ctrl1_req_i && ctrl2_req_i) sel = m_prio;
        else                                 sel = ctrl2_req_i;
        rs     = sel ? ctrl2_req_i : ctrl1_req_i;
        we_sel = sel ? ctrl2_we_i : ctrl1_we_i;
        preq   = rs && !full;
        ne     = (m_q.size() != 0);
        head   = ne ? m_q[0] : 1'b0;

        check("port_req", 32'(port_req_o), 32'(preq));
        if (preq) begin
            check("port_addr",  port_addr_o,          sel ? ctrl2_addr_i  : ctrl1_addr_i);
            check("port_we",    32'(port_we_o),       32'(we_sel));
            check("port_be",    32'(port_be_o),       32'(sel ? ctrl2_be_i : ctrl1_be_i));
            check("port_wdata", port_wdata_o,         sel ? ctrl2_wdata_i : ctrl1_wdata_i);
        end
        check("gnt1",    32'(ctrl1_gnt_o),    32'(port_gnt_i && preq && !sel));
        check("gnt2",    32'(ctrl2_gnt_o),    32'(port_gnt_i && preq && sel));
        check("rvalid1", 32'(ctrl1_rvalid_o), 32'(port_rvalid_i && ne && !head));
        check("rvalid2", 32'(ctrl2_rvalid_o), 32'(port_rvalid_i && ne && head));
        check("rdata1",  ctrl1_rdata_o, (ne && !head) ? port_rdata_i : 32'h0);
        check("rdata2",  ctrl2_rdata_o, (ne && head)  ? port_rdata_i : 32'h0);
        check("bad_state", 32'(bad_state_o), 32'(m_bad));

        if (rst_i) begin
            m_q.delete();
            m_prio = 0; m_lock = 0; m_lsel = 0; m_bad = 0;
        end else begin
            hs    = preq && port_gnt_i;
            drop  = m_lock && !rs;
            m_bad = (port_rvalid_i && !ne) || drop;
            if (port_rvalid_i && ne) void'(m_q.pop_front());
            if (hs && !we_sel) m_q.push_back(sel);
            if (hs) m_prio = !sel;
            if (drop || hs) m_lock = 0;
            else if (preq && !port_gnt_i) begin
                m_lock = 1;
                m_lsel = sel;
            end
        end
    endtask

    task automatic eval_cycle();
        @(negedge clk_i);
        model_step();
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_i = 1;
        eval_cycle();
        adv();
        rst_i = 0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            port_rvalid_i = 1;
            port_rdata_i  = 32'hD0D0_0000 + 32'(i);
            eval_cycle();
            adv();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_i = 1;
        m_prio = 0; m_lock = 0; m_lsel = 0; m_bad = 0;
        adv();
        adv();

        // Reset state: no requests means every output is quiet.
        eval_cycle();
        check("rst_port_req", 32'(port_req_o), 32'h0);
        check("rst_rdata1",   ctrl1_rdata_o,   32'h0);
        check("rst_bad",      32'(bad_state_o), 32'h0);
        adv();
        rst_i = 0;

        // Single ctrl1 read with zero-latency grant and a one-cycle response.
        do_reset();
        ctrl1_req_i = 1; ctrl1_addr_i = 32'h0000_1000; port_gnt_i = 1;
        eval_cycle();
        check("r16_gnt1", 32'(ctrl1_gnt_o), 32'h1);
        check("r16_addr", port_addr_o, 32'h0000_1000);
        adv();
        set_idle();
        port_rvalid_i = 1; port_rdata_i = 32'hA5A5_A5A5;
        eval_cycle();
        check("r16_rvalid1", 32'(ctrl1_rvalid_o), 32'h1);
        check("r16_rdata1",  ctrl1_rdata_o, 32'hA5A5_A5A5);
        check("r16_rvalid2", 32'(ctrl2_rvalid_o), 32'h0);
        adv();

        // Both controllers read every cycle: grants alternate and responses follow them.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_idle();
            ctrl1_req_i = 1; ctrl1_addr_i = 32'h100 + 32'(i);
            ctrl2_req_i = 1; ctrl2_addr_i = 32'h200 + 32'(i);
            port_gnt_i = 1;
            port_rvalid_i = (i > 0); port_rdata_i = 32'(i);
            eval_cycle();
            check("r17_gnt1",    32'(ctrl1_gnt_o),    32'((i % 2) == 0));
            check("r17_gnt2",    32'(ctrl2_gnt_o),    32'((i % 2) == 1));
            check("r17_rvalid1", 32'(ctrl1_rvalid_o), 32'((i % 2) == 1));
            check("r17_rvalid2", 32'(ctrl2_rvalid_o), 32'((i > 0) && ((i % 2) == 0)));
            adv();
        end
        drain(1);

        // A stalled ctrl2 request keeps the port although ctrl1 joins later.
        do_reset();
        ctrl2_req_i = 1; ctrl2_addr_i = 32'h0000_2222;
        ctrl1_addr_i = 32'h0000_1111;
        for (int i = 0; i < 3; i++) begin
            ctrl1_req_i = (i >= 1);
            eval_cycle();
            check("r18_addr_hold", port_addr_o, 32'h0000_2222);
            check("r18_gnt1_low",  32'(ctrl1_gnt_o), 32'h0);
            adv();
        end
        port_gnt_i = 1;
        eval_cycle();
        check("r18_gnt2", 32'(ctrl2_gnt_o), 32'h1);
        check("r18_addr_at_gnt", port_addr_o, 32'h0000_2222);
        adv();
        ctrl2_req_i = 0;
        eval_cycle();
        check("r18_gnt1_next", 32'(ctrl1_gnt_o), 32'h1);
        check("r18_addr_next", port_addr_o, 32'h0000_1111);
        adv();
        drain(2);

        // Full FIFO blocks a third read until the cycle after a response.
        do_reset();
        ctrl1_req_i = 1; ctrl1_addr_i = 32'h0000_3000; port_gnt_i = 1;
        for (int i = 0; i < 3; i++) begin
            eval_cycle();
            check("r19_req", 32'(port_req_o), 32'(i < 2));
            adv();
        end
        port_rvalid_i = 1;
        eval_cycle();
        check("r19_req_pop_cycle", 32'(port_req_o), 32'h0);
        check("r19_rvalid1", 32'(ctrl1_rvalid_o), 32'h1);
        adv();
        port_rvalid_i = 0;
        eval_cycle();
        check("r19_req_after_pop", 32'(port_req_o), 32'h1);
        check("r19_gnt1", 32'(ctrl1_gnt_o), 32'h1);
        adv();
        drain(2);

        // Orphan response with an empty FIFO.
        do_reset();
        port_rvalid_i = 1; port_rdata_i = 32'hDEAD_BEEF;
        eval_cycle();
        check("r20_rvalid1", 32'(ctrl1_rvalid_o), 32'h0);
        check("r20_rvalid2", 32'(ctrl2_rvalid_o), 32'h0);
        adv();
        set_idle();
        eval_cycle();
        check("r20_bad_pulse", 32'(bad_state_o), 32'h1);
        adv();
        eval_cycle();
        check("r20_bad_clear", 32'(bad_state_o), 32'h0);
        adv();

        // Reset with two reads outstanding and prio pointing at ctrl2.
        do_reset();
        ctrl2_req_i = 1; port_gnt_i = 1;
        eval_cycle();
        adv();
        ctrl2_req_i = 0; ctrl1_req_i = 1;
        eval_cycle();
        adv();
        do_reset();
        port_rvalid_i = 1;
        eval_cycle();
        check("r21_rvalid1", 32'(ctrl1_rvalid_o), 32'h0);
        check("r21_rvalid2", 32'(ctrl2_rvalid_o), 32'h0);
        adv();
        set_idle();
        ctrl1_req_i = 1; ctrl2_req_i = 1; port_gnt_i = 1;
        eval_cycle();
        check("r21_bad", 32'(bad_state_o), 32'h1);
        check("r21_prio_ctrl1", 32'(ctrl1_gnt_o), 32'h1);
        adv();
        do_reset();

        // Randomized traffic, including stalls, dropped requests, writes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_i         = ($urandom_range(0, 199) == 0);
            ctrl1_req_i   = ($urandom_range(0, 9) < 6);
            ctrl2_req_i   = ($urandom_range(0, 9) < 6);
            ctrl1_addr_i  = $urandom;
            ctrl2_addr_i  = $urandom;
            ctrl1_we_i    = ($urandom_range(0, 3) == 0);
            ctrl2_we_i    = ($urandom_range(0, 3) == 0);
            ctrl1_be_i    = 4'($urandom);
            ctrl2_be_i    = 4'($urandom);
            ctrl1_wdata_i = $urandom;
            ctrl2_wdata_i = $urandom;
            port_gnt_i    = ($urandom_range(0, 1) == 1);
            port_rvalid_i = ($urandom_range(0, 9) < 4);
            port_rdata_i  = $urandom;
            eval_cycle();
            adv();
        end
        rst_i = 0;
        set_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/obi_mux_2_to_1.md
OBI_MUX_2_TO_1 -- requirements
Module: obi_mux_2_to_1

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MAX_OUTSTANDING, 2, depth of the response-routing FIFO; legal values 1..8.
- WRITE_RESP, 0, 1 means accepted writes expect an rvalid; 0 means only reads do.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, the single clock.
- rst_i, in, 1, synchronous active-high reset.
- ctrl1_req_i / ctrl2_req_i, in, 1, controller address-phase request.
- ctrl1_gnt_o / ctrl2_gnt_o, out, 1, controller grant.
- ctrl1_addr_i / ctrl2_addr_i, in, 32, address.
- ctrl1_we_i / ctrl2_we_i, in, 1, write enable.
- ctrl1_be_i / ctrl2_be_i, in, 4, byte enables.
- ctrl1_wdata_i / ctrl2_wdata_i, in, 32, write data.
- ctrl1_rvalid_o / ctrl2_rvalid_o, out, 1, response valid.
- ctrl1_rdata_o / ctrl2_rdata_o, out, 32, response data.
- port_req_o, out, 1, request to the slave.
- port_gnt_i, in, 1, grant from the slave.
- port_addr_o, out, 32; port_we_o, out, 1; port_be_o, out, 4; port_wdata_o, out, 32: address-phase signals of the selected controller.
- port_rvalid_i, in, 1; port_rdata_i, in, 32: slave response.
- bad_state_o, out, 1, protocol-violation flag.

REQ-003 The block SHALL use one clock, clk_i; reset rst_i SHALL be synchronous and active-high.

Function
REQ-004 Address phase: sel SHALL choose ctrl1 or ctrl2.
- port_req_o = req_sel AND NOT fifo_full.
- port_addr/we/be/wdata_o = the selected controller's inputs.
- ctrlK_gnt_o = port_gnt_i AND port_req_o AND (sel == K); the unselected controller's gnt is 0.
- This path is combinational, so grant is zero-latency.

REQ-005 Arbitration SHALL be round-robin.
- With no lock and only one request active, sel SHALL be that requester.
- With both requesting, sel SHALL be the controller indicated by prio.
- prio resets to ctrl1.
- After an accepted handshake (port_req_o AND port_gnt_i) from controller K, prio SHALL become the other controller.

REQ-006 Lock: when port_req_o=1 and port_gnt_i=0, the block SHALL register lock=1 with locked_sel=sel.
- While locked, sel SHALL equal locked_sel regardless of prio or the other request.
- The lock SHALL clear on the handshake cycle, or if the locked controller drops its req (a protocol violation that is tolerated).

REQ-007 Response tracking SHALL use a FIFO of MAX_OUTSTANDING entries, each holding a 1-bit controller id.
- Push on each handshake where (we=0 OR WRITE_RESP=1).
- Pop on each port_rvalid_i when the FIFO is not empty.

REQ-008 When the FIFO is full, port_req_o and both gnt outputs SHALL be 0. Arbitration state SHALL hold.

REQ-009 Simultaneous push and pop in one cycle SHALL leave the count unchanged. A pop in the same cycle as full SHALL NOT unblock the grant until the next cycle, because fifo_full is registered-count based.

REQ-010 Response routing:
- ctrlK_rvalid_o = port_rvalid_i AND fifo_nonempty AND (head == K).
- Both ctrlK_rdata_o SHALL equal port_rdata_i whenever head == K; otherwise they SHALL be 0.

REQ-011 bad_state_o SHALL be a 1-cycle registered pulse, asserted the cycle after either of these:
- port_rvalid_i=1 while the FIFO is empty (the response is dropped);
- a locked requester deasserts req before its grant.

REQ-012 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING. The count SHALL be ceil(log2(MAX_OUTSTANDING+1)) bits wide and SHALL never exceed MAX_OUTSTANDING.

Reset
REQ-013 While rst_i=1 at a clk_i edge, the following SHALL clear on that edge, regardless of outstanding transactions: FIFO (count=0, pointers=0), lock=0, prio=ctrl1, bad_state_o=0.

REQ-014 During and after reset, all outputs SHALL follow REQ-004/REQ-010 from the cleared state. With no requests active, every req, gnt, and rvalid output is 0 and every rdata output is 0.

REQ-015 Responses outstanding at reset SHALL be discarded. A later rvalid with an empty FIFO pulses bad_state_o.

Verification
REQ-016 ctrl1 read of 0x1000, gnt_i=1, rvalid_i next cycle with rdata 0xA5A5A5A5 -> ctrl1_gnt_o=1 in the same cycle; ctrl1_rvalid_o=1 with 0xA5A5A5A5; ctrl2_rvalid_o=0.

REQ-017 Both controllers reading every cycle, gnt_i=1, one-cycle rvalid -> grants alternate ctrl1, ctrl2, ctrl1 …; each response is routed to the matching controller.

REQ-018 ctrl2 requests with gnt_i=0 for 3 cycles while ctrl1 asserts req in the 2nd cycle -> port_addr_o stays ctrl2's address until the grant; ctrl1 is granted next.

REQ-019 MAX_OUTSTANDING=2, three back-to-back reads, no rvalid -> the third is not granted (port_req_o=0) until one rvalid arrives.

REQ-020 port_rvalid_i=1 with the FIFO empty -> no ctrl rvalid; bad_state_o=1 for exactly one cycle on the next edge.

REQ-021 rst_i asserted with 2 outstanding transactions, then rvalid -> FIFO empty, prio=ctrl1, and that rvalid flags bad_state_o.
